// File: rtl/fp_mant_mul_seq_if.sv
// -----------------------------------------------------------------------------
// fp_mant_mul_seq_if
//   Operand/result handshake bundle for the iterative binary64 mantissa
//   multiplier front stage.
//
//   in_valid / in_ready / in_a / in_b   : operand pair, valid/ready
//   out_valid / out_ready               : result, held until accepted
//   out_sign                            : sign of the product
//   out_exp                             : signed E_a + E_b - 1023
//   out_prod                            : exact 106-bit significand product
//   out_cls                             : {nan, inf, zero}, all zero = normal
//
//   master : the side that supplies operands and consumes results
//   slave  : the multiplier itself
// -----------------------------------------------------------------------------
interface fp_mant_mul_seq_if;
   logic                in_valid;
   logic                in_ready;
   logic [63:0]         in_a;
   logic [63:0]         in_b;
   logic                out_valid;
   logic                out_ready;
   logic                out_sign;
   logic signed [12:0]  out_exp;
   logic [105:0]        out_prod;
   logic [2:0]          out_cls;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_prod, out_cls
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_prod, out_cls
   );
endinterface

// File: rtl/fp_mant_mul_seq.sv
// -----------------------------------------------------------------------------
// fp_mant_mul_seq
//   Iterative front stage of the double-precision multiplier. Captures two
//   binary64 operands, unpacks them, forms the exact 106-bit significand
//   product by shift-add (BITS_PER_CYC multiplier bits per cycle) and
//   classifies special operands. The result is presented with valid/ready
//   to the normalize/round stage.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : fp_mant_mul_seq_if.slave (operand and result handshakes)
//
// Parameters
//   BITS_PER_CYC : multiplier bits retired per RUN cycle (1, 2 or 4)
//   MANT_W       : significand width with hidden bit (53 for binary64)
//
// Build option
//   FP_MUL_EARLY_OUT_EN : when defined, operand pairs that classify as
//   nan/inf/zero skip the RUN phase and go straight to DONE.
// -----------------------------------------------------------------------------
module fp_mant_mul_seq #(
   parameter int BITS_PER_CYC = 1,
   parameter int MANT_W       = 53
) (
   input  logic               clk,
   input  logic               rst,
   fp_mant_mul_seq_if.slave   bus
);

   localparam int FRAC_W = MANT_W - 1;
   localparam int EXP_W  = 63 - FRAC_W;
   localparam int PROD_W = 2 * MANT_W;
   localparam int N      = (MANT_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
   localparam int IT_W   = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // {nan, inf, zero}; priority nan > inf > zero. Denormals count as zero.
   function automatic logic [2:0] classify(
      input logic [EXP_W-1:0]  ea,
      input logic [FRAC_W-1:0] fa,
      input logic [EXP_W-1:0]  eb,
      input logic [FRAC_W-1:0] fb
   );
      logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic nan, inf, zero;
      a_max  = &ea;
      b_max  = &eb;
      a_nan  = a_max & (|fa);
      b_nan  = b_max & (|fb);
      a_inf  = a_max & ~(|fa);
      b_inf  = b_max & ~(|fb);
      a_zero = ~(|ea);
      b_zero = ~(|eb);
      nan    = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
      inf    = (a_inf | b_inf) & ~nan;
      zero   = (a_zero | b_zero) & ~nan;
      return {nan, inf, zero};
   endfunction

   // Biased fields are zero-extended, so the 13-bit signed sum never wraps.
   function automatic logic signed [12:0] exp_sum(
      input logic [EXP_W-1:0] ea,
      input logic [EXP_W-1:0] eb
   );
      logic signed [12:0] xa, xb;
      xa = $signed(13'(ea));
      xb = $signed(13'(eb));
      return xa + xb - 13'sd1023;
   endfunction

   // Partial product of the (already shifted) multiplicand and one slice of
   // the multiplier.
   function automatic logic [PROD_W-1:0] slice_pp(
      input logic [PROD_W-1:0]       mc,
      input logic [BITS_PER_CYC-1:0] sl
   );
      logic [PROD_W-1:0] s;
      s = '0;
      for (int j = 0; j < BITS_PER_CYC; j++) begin
         if (sl[j]) s = s + (mc << j);
      end
      return s;
   endfunction

   // ---- stage p0: operand unpack and classification (combinational) ----
   logic [EXP_W-1:0]   ea_p0, eb_p0;
   logic [FRAC_W-1:0]  fa_p0, fb_p0;
   logic [2:0]         cls_p0;
   logic               special_p0;
   logic               sign_p0;
   logic signed [12:0] exp_p0;
   logic [MANT_W-1:0]  mant_a_p0, mant_b_p0;
   logic               accept;

   assign ea_p0      = bus.in_a[62:FRAC_W];
   assign eb_p0      = bus.in_b[62:FRAC_W];
   assign fa_p0      = bus.in_a[FRAC_W-1:0];
   assign fb_p0      = bus.in_b[FRAC_W-1:0];
   assign cls_p0     = classify(ea_p0, fa_p0, eb_p0, fb_p0);
   assign special_p0 = |cls_p0;
   assign sign_p0    = bus.in_a[63] ^ bus.in_b[63];
   // Special results carry exp=0 and prod=0; zeroing the significands makes
   // the shift-add produce the zero product without any extra muxing.
   assign exp_p0     = special_p0 ? 13'sd0 : exp_sum(ea_p0, eb_p0);
   assign mant_a_p0  = special_p0 ? '0 : {1'b1, fa_p0};
   assign mant_b_p0  = special_p0 ? '0 : {1'b1, fb_p0};
   assign accept     = bus.in_valid & (state == S_IDLE);

   // ---- stage p1: captured operands and shift-add accumulator ----
   logic [PROD_W-1:0]  mcand_p1;
   logic [MANT_W-1:0]  mplier_p1;
   logic [PROD_W-1:0]  acc_p1;
   logic               sign_p1;
   logic signed [12:0] exp_p1;
   logic [2:0]         cls_p1;
   logic [IT_W-1:0]    iter;
   logic               last_iter;

   assign last_iter = (iter == IT_W'(N - 1));

   // The multiplicand is pre-shifted each cycle and the multiplier consumed
   // from the bottom, which is the same as adding (mant_a*slice) << (B*iter)
   // without a wide variable shifter.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_p1  <= '0;
         mplier_p1 <= '0;
         acc_p1    <= '0;
         sign_p1   <= 1'b0;
         exp_p1    <= '0;
         cls_p1    <= '0;
         iter      <= '0;
      end else if (accept) begin
         mcand_p1  <= PROD_W'(mant_a_p0);
         mplier_p1 <= mant_b_p0;
         acc_p1    <= '0;
         sign_p1   <= sign_p0;
         exp_p1    <= exp_p0;
         cls_p1    <= cls_p0;
         iter      <= '0;
      end else if (state == S_RUN) begin
         acc_p1    <= acc_p1 + slice_pp(mcand_p1, mplier_p1[BITS_PER_CYC-1:0]);
         mcand_p1  <= mcand_p1 << BITS_PER_CYC;
         mplier_p1 <= mplier_p1 >> BITS_PER_CYC;
         iter      <= iter + 1'b1;
      end
   end

   // ---- control FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ---- control FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
`ifdef FP_MUL_EARLY_OUT_EN
               state_nxt = special_p0 ? S_DONE : S_RUN;
`else
               state_nxt = S_RUN;
`endif
            end
         end
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- control FSM: outputs ----
   always_comb begin
      bus.in_ready  = (state == S_IDLE);
      bus.out_valid = (state == S_DONE);
   end

   // Result registers are only written on accept or in RUN, so they are
   // frozen for as long as DONE waits on out_ready.
   assign bus.out_sign = sign_p1;
   assign bus.out_exp  = exp_p1;
   assign bus.out_prod = acc_p1;
   assign bus.out_cls  = cls_p1;

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_mant_mul_seq
//   Drives three multiplier instances (BITS_PER_CYC = 1, 2, 4) in lockstep
//   with identical operands and compares each against queued expectations.
// -----------------------------------------------------------------------------
module tb_fp_mant_mul_seq;

   typedef struct packed {
      logic               sign;
      logic signed [12:0] exp;
      logic [105:0]       prod;
      logic [2:0]         cls;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;

   always #5 clk = ~clk;

   fp_mant_mul_seq_if bus1 ();
   fp_mant_mul_seq_if bus2 ();
   fp_mant_mul_seq_if bus4 ();

   assign bus1.in_valid = in_valid;  assign bus1.in_a = in_a;
   assign bus1.in_b = in_b;          assign bus1.out_ready = out_ready;
   assign bus2.in_valid = in_valid;  assign bus2.in_a = in_a;
   assign bus2.in_b = in_b;          assign bus2.out_ready = out_ready;
   assign bus4.in_valid = in_valid;  assign bus4.in_a = in_a;
   assign bus4.in_b = in_b;          assign bus4.out_ready = out_ready;

   fp_mant_mul_seq #(.BITS_PER_CYC(1), .MANT_W(53)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   fp_mant_mul_seq #(.BITS_PER_CYC(2), .MANT_W(53)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   fp_mant_mul_seq #(.BITS_PER_CYC(4), .MANT_W(53)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   logic [2:0]         ov, ir, sgn;
   logic signed [12:0] oexp [3];
   logic [105:0]       oprod [3];
   logic [2:0]         ocls [3];

   assign ov  = {bus4.out_valid, bus2.out_valid, bus1.out_valid};
   assign ir  = {bus4.in_ready,  bus2.in_ready,  bus1.in_ready};
   assign sgn = {bus4.out_sign,  bus2.out_sign,  bus1.out_sign};
   assign oexp[0]  = bus1.out_exp;  assign oexp[1]  = bus2.out_exp;  assign oexp[2]  = bus4.out_exp;
   assign oprod[0] = bus1.out_prod; assign oprod[1] = bus2.out_prod; assign oprod[2] = bus4.out_prod;
   assign ocls[0]  = bus1.out_cls;  assign ocls[1]  = bus2.out_cls;  assign ocls[2]  = bus4.out_cls;

   int total = 0;
   int bad   = 0;
   exp_t sb[$];

   // captured by run_op / release_out
   logic [2:0]         seen, ir_acc, busy_ir, rel_ov, rel_ir, got_sign;
   logic signed [12:0] got_exp [3];
   logic [105:0]       got_prod [3];
   logic [2:0]         got_cls [3];
   int                 lat [3];

   function automatic int n_of(input int k);
      int b;
      b = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
      return (53 + b - 1) / b;
   endfunction

   function automatic int lat_want(input int k, input logic [2:0] c);
`ifdef FP_MUL_EARLY_OUT_EN
      if (c != 3'b000) return 1;
`endif
      return n_of(k) + 1;
   endfunction

   function automatic exp_t mk(input logic s, input logic signed [12:0] e,
                               input logic [105:0] p, input logic [2:0] c);
      exp_t r;
      r.sign = s; r.exp = e; r.prod = p; r.cls = c;
      return r;
   endfunction

   // Reference: full-width multiply and a priority chain for the class.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
      exp_t r;
      logic [10:0] ea, eb;
      logic [51:0] fa, fb;
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [105:0] xa, xb;
      ea = a[62:52]; eb = b[62:52]; fa = a[51:0]; fb = b[51:0];
      a_nan = (ea == 11'h7FF) && (fa != 0);  b_nan = (eb == 11'h7FF) && (fb != 0);
      a_inf = (ea == 11'h7FF) && (fa == 0);  b_inf = (eb == 11'h7FF) && (fb == 0);
      a_zero = (ea == 0);                    b_zero = (eb == 0);
      r.sign = a[63] ^ b[63];
      r.exp = '0; r.prod = '0;
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) r.cls = 3'b100;
      else if (a_inf || b_inf)   r.cls = 3'b010;
      else if (a_zero || b_zero) r.cls = 3'b001;
      else begin
         r.cls  = 3'b000;
         xa = {53'd0, 1'b1, fa};
         xb = {53'd0, 1'b1, fb};
         r.prod = xa * xb;
         r.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
      end
      return r;
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [10:0] e;
      logic [63:0] w;
      if ($urandom_range(0, 7) == 0)      e = 11'h7FF;
      else if ($urandom_range(0, 7) == 0) e = 11'h000;
      else                                e = 11'($urandom_range(1, 2046));
      w = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) w[51:0] = '0;
      return {w[63], e, w[51:0]};
   endfunction

   // Present one operand pair, optionally keep hammering in_valid with junk
   // while busy, and wait (bounded) until every instance shows out_valid.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit noise);
      int edges;
      @(negedge clk);
      in_a = a; in_b = b; in_valid = 1'b1;
      ir_acc = ir;
      @(posedge clk);
      #1 in_valid = 1'b0;
      seen = '0; busy_ir = '0; edges = 0;
      for (int k = 0; k < 3; k++) lat[k] = -1;
      do begin
         if (noise) begin
            in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
         end
         @(negedge clk);
         edges++;
         busy_ir |= ir;
         for (int k = 0; k < 3; k++) begin
            if (!seen[k] && ov[k]) begin seen[k] = 1'b1; lat[k] = edges; end
         end
      end while (seen != 3'b111 && edges < 200);
      in_valid = 1'b0;
      got_sign = sgn;
      for (int k = 0; k < 3; k++) begin
         got_exp[k] = oexp[k]; got_prod[k] = oprod[k]; got_cls[k] = ocls[k];
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      rel_ov = ov; rel_ir = ir;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (ov !== 3'b000) begin bad++; $display("FAIL reset_out_valid got %b want 000", ov); end
      total++; if (ir !== 3'b111) begin bad++; $display("FAIL reset_in_ready got %b want 111", ir); end
      total++; if (sgn !== 3'b000) begin bad++; $display("FAIL reset_sign got %b want 000", sgn); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (oprod[k] !== '0 || oexp[k] !== '0 || ocls[k] !== '0) begin
            bad++;
            $display("FAIL reset_data inst %0d got prod=%h exp=%0d cls=%b want 0/0/0",
                     k, oprod[k], oexp[k], ocls[k]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      total++; if (ir !== 3'b111) begin bad++; $display("FAIL post_reset_in_ready got %b want 111", ir); end
   endtask

   task automatic test_arith();
      logic [63:0]  ta [22];
      logic [63:0]  tb_op [22];
      exp_t         te [22];
      exp_t         e;
      logic [105:0] one, m53;
      one = 106'd1;
      m53 = (one << 53) - one;
      ta[0]  = 64'h3FF0000000000000; tb_op[0]  = 64'h3FF0000000000000; te[0]  = mk(0, 13'sd1023, one << 104, 3'b000);
      ta[1]  = 64'h3FF8000000000000; tb_op[1]  = 64'h3FF8000000000000; te[1]  = mk(0, 13'sd1023, (one << 105) | (one << 102), 3'b000);
      ta[2]  = 64'hC000000000000000; tb_op[2]  = 64'h4008000000000000; te[2]  = mk(1, 13'sd1025, (one << 104) | (one << 103), 3'b000);
      ta[3]  = 64'h0000000000000000; tb_op[3]  = 64'h7FF0000000000000; te[3]  = mk(0, 13'sd0, '0, 3'b100);
      ta[4]  = 64'h7FF0000000000000; tb_op[4]  = 64'h0000000000000000; te[4]  = mk(0, 13'sd0, '0, 3'b100);
      ta[5]  = 64'h7FF8000000000000; tb_op[5]  = 64'h3FF0000000000000; te[5]  = mk(0, 13'sd0, '0, 3'b100);
      ta[6]  = 64'h7FF0000000000000; tb_op[6]  = 64'hC000000000000000; te[6]  = mk(1, 13'sd0, '0, 3'b010);
      ta[7]  = 64'h8000000000000000; tb_op[7]  = 64'h4008000000000000; te[7]  = mk(1, 13'sd0, '0, 3'b001);
      ta[8]  = 64'h000FFFFFFFFFFFFF; tb_op[8]  = 64'h3FF0000000000000; te[8]  = mk(0, 13'sd0, '0, 3'b001);
      ta[9]  = 64'h0010000000000000; tb_op[9]  = 64'h0010000000000000; te[9]  = mk(0, -13'sd1021, one << 104, 3'b000);
      ta[10] = 64'h7FEFFFFFFFFFFFFF; tb_op[10] = 64'h7FEFFFFFFFFFFFFF; te[10] = mk(0, 13'sd3069, m53 * m53, 3'b000);
      ta[11] = 64'hFFF0000000000000; tb_op[11] = 64'h7FF0000000000000; te[11] = mk(1, 13'sd0, '0, 3'b010);
      ta[12] = 64'h3FF0000000000000; tb_op[12] = 64'hFFF8000000000000; te[12] = mk(1, 13'sd0, '0, 3'b100);
      ta[13] = 64'h7FF8000000000000; tb_op[13] = 64'h0000000000000000; te[13] = mk(0, 13'sd0, '0, 3'b100);
      for (int i = 14; i < 22; i++) begin
         ta[i] = rnd_op(); tb_op[i] = rnd_op(); te[i] = model(ta[i], tb_op[i]);
      end
      for (int i = 0; i < 22; i++) begin
         sb.push_back(te[i]);
         run_op(ta[i], tb_op[i], 1'b0);
         e = sb.pop_front();
         total++; if (ir_acc !== 3'b111) begin bad++; $display("FAIL accept_ready vec %0d got %b want 111", i, ir_acc); end
         total++; if (seen !== 3'b111) begin bad++; $display("FAIL valid_timeout vec %0d got %b want 111", i, seen); end
         for (int k = 0; k < 3; k++) begin
            total++; if (lat[k] != lat_want(k, e.cls)) begin bad++; $display("FAIL latency vec %0d inst %0d got %0d want %0d", i, k, lat[k], lat_want(k, e.cls)); end
            total++; if (got_sign[k] !== e.sign) begin bad++; $display("FAIL sign vec %0d inst %0d got %b want %b", i, k, got_sign[k], e.sign); end
            total++; if (got_exp[k] !== e.exp) begin bad++; $display("FAIL exp vec %0d inst %0d got %0d want %0d", i, k, got_exp[k], e.exp); end
            total++; if (got_prod[k] !== e.prod) begin bad++; $display("FAIL prod vec %0d inst %0d got %h want %h", i, k, got_prod[k], e.prod); end
            total++; if (got_cls[k] !== e.cls) begin bad++; $display("FAIL cls vec %0d inst %0d got %b want %b", i, k, got_cls[k], e.cls); end
         end
         release_out();
         total++; if (rel_ov !== 3'b000) begin bad++; $display("FAIL release_valid vec %0d got %b want 000", i, rel_ov); end
         total++; if (rel_ir !== 3'b111) begin bad++; $display("FAIL release_ready vec %0d got %b want 111", i, rel_ir); end
      end
   endtask

   task automatic test_hold();
      exp_t e;
      logic [105:0] m53;
      m53 = (106'd1 << 53) - 106'd1;
      sb.push_back(mk(0, 13'sd1023, m53 * m53, 3'b000));
      run_op(64'h3FFFFFFFFFFFFFFF, 64'h3FFFFFFFFFFFFFFF, 1'b0);
      e = sb.pop_front();
      total++; if (seen !== 3'b111) begin bad++; $display("FAIL hold_timeout got %b want 111", seen); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++; if (ov !== 3'b111) begin bad++; $display("FAIL hold_valid cyc %0d got %b want 111", c, ov); end
         for (int k = 0; k < 3; k++) begin
            total++;
            if (oprod[k] !== e.prod || oexp[k] !== e.exp || ocls[k] !== e.cls || sgn[k] !== e.sign) begin
               bad++;
               $display("FAIL hold_data cyc %0d inst %0d got prod=%h exp=%0d want prod=%h exp=%0d",
                        c, k, oprod[k], oexp[k], e.prod, e.exp);
            end
         end
      end
      release_out();
      total++; if (rel_ov !== 3'b000) begin bad++; $display("FAIL hold_release_valid got %b want 000", rel_ov); end
      total++; if (rel_ir !== 3'b111) begin bad++; $display("FAIL hold_release_ready got %b want 111", rel_ir); end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      sb.push_back(model(64'h3FF8000000000000, 64'h3FF8000000000000));
      run_op(64'h3FF8000000000000, 64'h3FF8000000000000, 1'b1);
      e = sb.pop_front();
      total++; if (busy_ir !== 3'b000) begin bad++; $display("FAIL busy_in_ready got %b want 000", busy_ir); end
      total++; if (seen !== 3'b111) begin bad++; $display("FAIL busy_timeout got %b want 111", seen); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (got_prod[k] !== e.prod || got_exp[k] !== e.exp || got_cls[k] !== e.cls) begin
            bad++;
            $display("FAIL busy_result inst %0d got prod=%h exp=%0d want prod=%h exp=%0d",
                     k, got_prod[k], got_exp[k], e.prod, e.exp);
         end
      end
      release_out();
      total++; if (rel_ir !== 3'b111) begin bad++; $display("FAIL busy_release_ready got %b want 111", rel_ir); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      in_a = 64'hBFF8000000000000; in_b = 64'h4008000000000000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (ov !== 3'b000) begin bad++; $display("FAIL midrst_valid got %b want 000", ov); end
      total++; if (ir !== 3'b111) begin bad++; $display("FAIL midrst_ready got %b want 111", ir); end
      total++; if (sgn !== 3'b000) begin bad++; $display("FAIL midrst_sign got %b want 000", sgn); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (oprod[k] !== '0 || oexp[k] !== '0 || ocls[k] !== '0) begin
            bad++;
            $display("FAIL midrst_data inst %0d got prod=%h exp=%0d cls=%b want 0/0/0", k, oprod[k], oexp[k], ocls[k]);
         end
      end
      sb.push_back(mk(0, 13'sd1023, 106'd1 << 104, 3'b000));
      run_op(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         total++; if (lat[k] != lat_want(k, e.cls)) begin bad++; $display("FAIL midrst_latency inst %0d got %0d want %0d", k, lat[k], lat_want(k, e.cls)); end
         total++;
         if (got_prod[k] !== e.prod || got_exp[k] !== e.exp || got_cls[k] !== e.cls || got_sign[k] !== e.sign) begin
            bad++;
            $display("FAIL midrst_result inst %0d got prod=%h exp=%0d want prod=%h exp=%0d",
                     k, got_prod[k], got_exp[k], e.prod, e.exp);
         end
      end
      release_out();
      total++; if (rel_ir !== 3'b111) begin bad++; $display("FAIL midrst_release_ready got %b want 111", rel_ir); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_hold();
      test_busy_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
